board_ctrl: RTL

- Parametrised successor to the SoC-top button/reset/clock-step logic.
- Debounces NUM_BTN active-low push buttons and sequences CPU reset.
- Provides run and single-step modes through a CPU clock enable, not a muxed clock.
- Exposes button levels and sticky press flags as a bus-readable peripheral.

---
 rtl/board_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/board_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/board_ctrl_pkg.sv
// Shared FSM state codes, register offsets and ID constant for the board
// control peripheral.
package board_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } state_t;

  localparam logic [1:0] REG_LEVEL  = 2'd0;
  localparam logic [1:0] REG_STICKY = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam logic [31:0] BOARD_ID = 32'h42C0_0001;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: synchronises an active-low pad and accepts a new
// level only after it has been stable for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  // Press/release pulses are registered alongside the level update so they
  // coincide with the cycle the new level becomes visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= ~raw_n;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable  <= r_sync2;
        r_cnt     <= '0;
        r_press   <= r_sync2;
        r_release <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level    = r_stable;
  assign press    = r_press;
  assign released = r_release;

endmodule

// File: rtl/board_ctrl.sv
// Board control top: debounced buttons, CPU reset sequencing, run/step clock
// enable and a small read-only bus register file.
module board_ctrl
  import board_ctrl_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int RST_HOLD        = 256,
  parameter int BTN_RESET       = 0,
  parameter int BTN_MODE        = 1,
  parameter int BTN_STEP        = 2,
  parameter int ADDR_W          = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               ren,
  input  logic [ADDR_W-1:0]  address,
  output logic [31:0]        data_out,
  output logic               cpu_reset_n,
  output logic               cpu_clk_en,
  output logic               step_mode,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic               w_unused_bits;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .raw_n   (btn_n[g]),
      .level   (w_level[g]),
      .press   (w_press[g]),
      .released(w_release[g])
    );
  end

  assign w_unused_bits = ^{w_release, address};

  state_t             r_state;
  state_t             w_state_next;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic               r_step_mode;
  logic               w_step_mode_next;
  logic               r_step_en;
  logic               w_step_en_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_step_mode <= 1'b0;
      r_step_en   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_step_mode <= w_step_mode_next;
      r_step_en   <= w_step_en_next;
    end
  end

  // Pulse priority is reset > mode > step; a dropped step never reaches r_step_en.
  always_comb begin
    w_state_next     = r_state;
    w_hold_cnt_next  = '0;
    w_step_mode_next = r_step_mode;
    w_step_en_next   = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (w_press[BTN_RESET]) begin
          w_hold_cnt_next = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = ST_WAIT_REL;
        end else begin
          w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (w_press[BTN_RESET]) begin
          w_state_next = ST_HOLD;
        end else if (w_level == '0) begin
          w_state_next = r_step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_press[BTN_RESET]) begin
          w_state_next = ST_HOLD;
        end else if (w_press[BTN_MODE]) begin
          w_step_mode_next = 1'b1;
          w_state_next     = ST_STEP;
        end
      end
      ST_STEP: begin
        if (w_press[BTN_RESET]) begin
          w_state_next = ST_HOLD;
        end else if (w_press[BTN_MODE]) begin
          w_step_mode_next = 1'b0;
          w_state_next     = ST_RUN;
        end else if (w_press[BTN_STEP]) begin
          w_step_en_next = 1'b1;
        end
      end
      default: w_state_next = ST_HOLD;
    endcase
  end

  assign cpu_reset_n = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign cpu_clk_en  = (r_state == ST_RUN) || r_step_en;
  assign step_mode   = r_step_mode;
  assign btn_level   = w_level;

  logic [NUM_BTN-1:0] r_sticky;
  logic [NUM_BTN-1:0] w_sticky_clr;
  logic [1:0]         w_reg_sel;
  logic [31:0]        w_read_data;
  logic [31:0]        r_data_out;

  assign w_reg_sel    = address[3:2];
  assign w_sticky_clr = (ren && (w_reg_sel == REG_STICKY)) ? r_sticky : '0;

  // Clear only what the read returned; a same-cycle press still sets its flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_press;
    end
  end

  always_comb begin
    w_read_data = '0;
    case (w_reg_sel)
      REG_LEVEL:  w_read_data = 32'(w_level);
      REG_STICKY: w_read_data = 32'(r_sticky);
      REG_STATUS: w_read_data = {27'd0, r_step_mode, 2'b00, r_state};
      REG_ID:     w_read_data = BOARD_ID;
      default:    w_read_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (ren) begin
      r_data_out <= w_read_data;
    end
  end

  assign data_out = r_data_out;

endmodule
